jam_referee: RTL and testbench
==============================

Name: jam_referee

Overview:
Sequencing controller for the traffic-jam puzzle board. It owns the board state (2N+1 slots, N right-facing and N left-facing players) and arbitrates move requests from two requesters: the right team and the left team. It validates each served request against the puzzle rules, applies legal moves, counts them, and reports solved (done) or dead-end (stuck) positions. It sits between player/solver agents and the board datapath.

Parameters:
N, 3, players per team; board has S = 2N+1 slots, indices 0..S-1
CW, 8, move-counter width
BACKSLIDE, 0, 1 allows a slide in either direction; 0 allows forward slides only

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
r_req  in  1  right team requests a move
r_pos  in  SW  slot of the right-facing player to move; SW = clog2(S)
l_req  in  1  left team requests a move
l_pos  in  SW  slot of the left-facing player to move
r_gnt  out  1  one-cycle pulse: right request accepted and applied
l_gnt  out  1  one-cycle pulse: left request accepted and applied
rej  out  1  one-cycle pulse: served request was illegal; board unchanged
board  out  2*S  slot i at bits [2i+1:2i]; encoding EMPTY=0, LEFT=1, RIGHT=2
empty_pos  out  SW  index of the empty slot
moves  out  CW  accepted-move count
done  out  1  board is the swapped arrangement
stuck  out  1  not done and no legal move exists for either team

Behaviour:
- Clock port is named clock; reset is synchronous active-high, and all state responds only at a rising clock edge.
- Reset values: slots 0..N-1 = RIGHT, slot N = EMPTY, slots N+1..2N = LEFT. empty_pos = N, moves = 0. All pulses, done and stuck are 0. State is PLAY and the arbitration pointer is RIGHT. Reset asserted at any time, including in ACK, DONE or STUCK, restores these values at the next edge.
- FSM states:
  - PLAY: requests are sampled.
  - ACK: one-cycle response window; requests are ignored.
  - DONE and STUCK: absorbing until reset; requests are ignored and gnt/rej stay 0.
- PLAY arbitration:
  - No request: stay in PLAY.
  - One team requesting: that team is served.
  - Both teams requesting: the pointer's team is served.
  - After any service, whether accepted or rejected, the pointer moves to the other team.
- Legality of a served (team, pos). Let e = empty_pos.
  - pos < S, and slot[pos] holds the team's own colour.
  - RIGHT slide: e == pos+1.
  - LEFT slide: e == pos-1.
  - With BACKSLIDE=1, a slide is legal for either team when |pos-e| == 1.
  - RIGHT jump: e == pos+2 and slot[pos+1] == LEFT.
  - LEFT jump: e == pos-2 and slot[pos-1] == RIGHT.
  - Index arithmetic is performed at SW+1 bits so that underflow and overflow can never match e.
- Timing, served at edge T:
  - If legal: slot[e] gets the colour, slot[pos] becomes EMPTY, empty_pos becomes pos, moves increments (saturating at 2^CW-1), and the corresponding gnt is high for the cycle after T.
  - If illegal: board is unchanged and rej is high for the cycle after T.
  - State becomes ACK at T.
- Leaving ACK, evaluated on the updated board:
  - done → DONE.
  - Otherwise stuck → STUCK.
  - Otherwise → PLAY.
- done and stuck are registered from the board and update in the same cycle as the gnt pulse.
- Requesters must hold req/pos stable until they see gnt or rej. The ACK cycle gives them time to drop req.
- Stuck scan: check every slot holding a piece with its owning team's legality rule. stuck = no legal move AND NOT done.

Decomposition:
- Package jam_pkg holds: the Cell enum (EMPTY, LEFT, RIGHT) with its 2-bit encoding, the FSM state enum, and the Team type (RIGHT_T, LEFT_T).
- One combinational sub-module, jam_move_check(board, team, pos, empty) → legal. It is instantiated once for the served request and S times for the stuck scan.

Test Plan:
- Reset: release reset → board R,R,R,E,L,L,L; empty_pos=3; moves=0; done=0; stuck=0; no pulses.
- Illegal move: l_req pos=6 → rej pulse one cycle after the edge; board unchanged; moves=0. Then r_req pos=4 (not own colour) → rej.
- Simultaneous requests: r_req pos=2 and l_req pos=4 held together after reset → r_gnt, board RRERLLL, moves=1. Next PLAY sample → l_gnt (jump 4→2), board RRLRELL, moves=2.
- Full solution: sources 2,4,5,3,1,0,2,4,6,5,3,1,2,4,3 with teams R,L,L,R,R,R,L,L,L,R,R,R,L,L,R → 15 grants, board LLLERRR, done=1 with the 15th gnt, moves=15. Further requests → no gnt or rej.
- Stuck (BACKSLIDE=0): r moves 2, 1, 0 → board ERRRLLL; stuck=1 with the third gnt; FSM in STUCK. Reset → initial board, stuck=0.
- Reset mid-operation: assert reset during an ACK cycle after a grant → next cycle shows initial board, pulses 0, moves=0, and pointer RIGHT (verified by a simultaneous request that grants right).

Source files
------------

// File: rtl/jam_pkg.sv
// jam_pkg: shared types for the traffic-jam referee.
//   cell_t  : slot contents, 2-bit encoding EMPTY=0, LEFT=1, RIGHT=2
//   state_t : referee FSM states
//   team_t  : requesting team
package jam_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } cell_t;

    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        ACK   = 2'd1,
        DONE  = 2'd2,
        STUCK = 2'd3
    } state_t;

    typedef enum logic {
        RIGHT_T = 1'b0,
        LEFT_T  = 1'b1
    } team_t;

    // Colour a team places on the board.
    function automatic cell_t team_cell(input team_t t);
        return (t == LEFT_T) ? LEFT : RIGHT;
    endfunction

endpackage

// File: rtl/jam_move_check.sv
// jam_move_check: combinational legality test for one (team, pos) move.
//   board : packed board, slot i at [2i+1:2i]
//   team  : team attempting the move
//   pos   : slot of the piece to move
//   empty : index of the empty slot
//   legal : move obeys the puzzle rules
module jam_move_check
    import jam_pkg::*;
#(
    parameter int unsigned N         = 3,
    parameter int unsigned BACKSLIDE = 0,
    localparam int unsigned S        = 2 * N + 1,
    localparam int unsigned SW       = $clog2(S)
) (
    input  logic [2*S-1:0] board,
    input  team_t          team,
    input  logic [SW-1:0]  pos,
    input  logic [SW-1:0]  empty,
    output logic           legal
);

    // One extra bit so pos-1/pos-2 underflow and pos+1/pos+2 overflow never equal empty.
    localparam int unsigned XW = SW + 1;

    // Out-of-range indices read as EMPTY.
    function automatic cell_t cell_at(input logic [2*S-1:0] b, input logic [XW-1:0] idx);
        cell_t c;
        c = EMPTY;
        for (int unsigned i = 0; i < S; i++) begin
            if (idx == XW'(i)) c = cell_t'(b[2*i +: 2]);
        end
        return c;
    endfunction

    logic [XW-1:0] w_p;
    logic [XW-1:0] w_e;
    logic          w_own;
    logic          w_fwd;
    logic          w_back;
    logic          w_jump;

    always_comb begin
        w_p    = {1'b0, pos};
        w_e    = {1'b0, empty};
        w_own  = (w_p < XW'(S)) && (cell_at(board, w_p) == team_cell(team));
        w_fwd  = (team == RIGHT_T) ? (w_e == w_p + XW'(1)) : (w_e == w_p - XW'(1));
        w_back = (BACKSLIDE != 0) && ((w_e == w_p + XW'(1)) || (w_e == w_p - XW'(1)));
        if (team == RIGHT_T) begin
            w_jump = (w_e == w_p + XW'(2)) && (cell_at(board, w_p + XW'(1)) == LEFT);
        end else begin
            w_jump = (w_e == w_p - XW'(2)) && (cell_at(board, w_p - XW'(1)) == RIGHT);
        end
        legal = w_own && (w_fwd || w_back || w_jump);
    end

endmodule

// File: rtl/jam_referee.sv
// jam_referee: arbitrates right/left move requests on the traffic-jam board,
// applies legal moves, counts them and flags solved or dead-end positions.
//   clock, reset       : rising-edge clock, synchronous active-high reset
//   r_req/r_pos        : right team request and piece slot
//   l_req/l_pos        : left team request and piece slot
//   r_gnt, l_gnt, rej  : one-cycle result pulses for the served request
//   board, empty_pos   : current board and empty slot index
//   moves              : saturating accepted-move count
//   done, stuck        : solved / no-legal-move flags
module jam_referee
    import jam_pkg::*;
#(
    parameter int unsigned N         = 3,
    parameter int unsigned CW        = 8,
    parameter int unsigned BACKSLIDE = 0,
    localparam int unsigned S        = 2 * N + 1,
    localparam int unsigned SW       = $clog2(S)
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           r_req,
    input  logic [SW-1:0]  r_pos,
    input  logic           l_req,
    input  logic [SW-1:0]  l_pos,
    output logic           r_gnt,
    output logic           l_gnt,
    output logic           rej,
    output logic [2*S-1:0] board,
    output logic [SW-1:0]  empty_pos,
    output logic [CW-1:0]  moves,
    output logic           done,
    output logic           stuck
);

    // Starting arrangement: RIGHT pieces low, EMPTY centre, LEFT pieces high.
    function automatic logic [2*S-1:0] init_board();
        logic [2*S-1:0] b;
        b = '0;
        for (int unsigned i = 0; i < S; i++) begin
            if (i < N)      b[2*i +: 2] = RIGHT;
            else if (i > N) b[2*i +: 2] = LEFT;
        end
        return b;
    endfunction

    // Solved arrangement: the two teams swapped.
    function automatic logic [2*S-1:0] goal_board();
        logic [2*S-1:0] b;
        b = '0;
        for (int unsigned i = 0; i < S; i++) begin
            if (i < N)      b[2*i +: 2] = LEFT;
            else if (i > N) b[2*i +: 2] = RIGHT;
        end
        return b;
    endfunction

    localparam logic [2*S-1:0] INIT_BOARD = init_board();
    localparam logic [2*S-1:0] GOAL_BOARD = goal_board();

    state_t         r_state, w_state_nxt;
    team_t          r_ptr, w_ptr_nxt;
    logic [2*S-1:0] r_board, w_board_nxt;
    logic [SW-1:0]  r_empty, w_empty_nxt;
    logic [CW-1:0]  r_moves, w_moves_nxt;
    logic           r_rgnt, w_rgnt_nxt;
    logic           r_lgnt, w_lgnt_nxt;
    logic           r_rej, w_rej_nxt;
    logic           r_done, w_done_nxt;
    logic           r_stuck, w_stuck_nxt;

    logic           w_serve;
    team_t          w_team;
    logic [SW-1:0]  w_pos;
    logic           w_legal;
    logic [S-1:0]   w_scan;

    // Arbitration: a lone requester wins; on contention the pointer decides.
    assign w_serve = (r_state == PLAY) && (r_req || l_req);
    assign w_team  = (r_req && l_req) ? r_ptr : (r_req ? RIGHT_T : LEFT_T);
    assign w_pos   = (w_team == RIGHT_T) ? r_pos : l_pos;

    jam_move_check #(.N(N), .BACKSLIDE(BACKSLIDE)) u_served (
        .board (r_board),
        .team  (w_team),
        .pos   (w_pos),
        .empty (r_empty),
        .legal (w_legal)
    );

    // Stuck scan runs on the next board so done/stuck line up with the grant pulse.
    for (genvar g = 0; g < S; g++) begin : g_scan
        cell_t w_cell;
        team_t w_owner;
        logic  w_ok;
        assign w_cell  = cell_t'(w_board_nxt[2*g +: 2]);
        assign w_owner = (w_cell == LEFT) ? LEFT_T : RIGHT_T;
        jam_move_check #(.N(N), .BACKSLIDE(BACKSLIDE)) u_scan (
            .board (w_board_nxt),
            .team  (w_owner),
            .pos   (SW'(g)),
            .empty (w_empty_nxt),
            .legal (w_ok)
        );
        assign w_scan[g] = w_ok && (w_cell != EMPTY);
    end

    assign w_done_nxt  = (w_board_nxt == GOAL_BOARD);
    assign w_stuck_nxt = !w_done_nxt && !(|w_scan);

    // State and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= PLAY;
            r_ptr   <= RIGHT_T;
            r_board <= INIT_BOARD;
            r_empty <= SW'(N);
            r_moves <= '0;
            r_rgnt  <= 1'b0;
            r_lgnt  <= 1'b0;
            r_rej   <= 1'b0;
            r_done  <= 1'b0;
            r_stuck <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_board <= w_board_nxt;
            r_empty <= w_empty_nxt;
            r_moves <= w_moves_nxt;
            r_rgnt  <= w_rgnt_nxt;
            r_lgnt  <= w_lgnt_nxt;
            r_rej   <= w_rej_nxt;
            r_done  <= w_done_nxt;
            r_stuck <= w_stuck_nxt;
        end
    end

    // Next-state and move application.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_board_nxt = r_board;
        w_empty_nxt = r_empty;
        w_moves_nxt = r_moves;
        w_rgnt_nxt  = 1'b0;
        w_lgnt_nxt  = 1'b0;
        w_rej_nxt   = 1'b0;

        case (r_state)
            PLAY: begin
                if (w_serve) begin
                    w_state_nxt = ACK;
                    w_ptr_nxt   = (w_team == RIGHT_T) ? LEFT_T : RIGHT_T;
                    if (w_legal) begin
                        for (int unsigned i = 0; i < S; i++) begin
                            if (r_empty == SW'(i)) w_board_nxt[2*i +: 2] = team_cell(w_team);
                            if (w_pos == SW'(i))   w_board_nxt[2*i +: 2] = EMPTY;
                        end
                        w_empty_nxt = w_pos;
                        if (r_moves != {CW{1'b1}}) w_moves_nxt = r_moves + CW'(1);
                        w_rgnt_nxt  = (w_team == RIGHT_T);
                        w_lgnt_nxt  = (w_team == LEFT_T);
                    end else begin
                        w_rej_nxt   = 1'b1;
                    end
                end
            end
            ACK: begin
                if (r_done)       w_state_nxt = DONE;
                else if (r_stuck) w_state_nxt = STUCK;
                else              w_state_nxt = PLAY;
            end
            DONE, STUCK: begin
                w_state_nxt = r_state;
            end
            default: w_state_nxt = PLAY;
        endcase
    end

    assign r_gnt     = r_rgnt;
    assign l_gnt     = r_lgnt;
    assign rej       = r_rej;
    assign board     = r_board;
    assign empty_pos = r_empty;
    assign moves     = r_moves;
    assign done      = r_done;
    assign stuck     = r_stuck;

endmodule

// File: tb/tb_jam_referee.sv
// tb_jam_referee: directed scoreboard bench for jam_referee (N=3, BACKSLIDE=0).
// Expected results are queued as requests are issued; a negedge monitor pops
// one entry per gnt/rej pulse and compares the whole visible state.
module tb_jam_referee;

    localparam int N  = 3;
    localparam int S  = 7;
    localparam int SW = 3;
    localparam int CW = 8;

    localparam int K_RGNT = 0;
    localparam int K_LGNT = 1;
    localparam int K_REJ  = 2;

    logic          clock;
    logic          reset;
    logic          r_req;
    logic [SW-1:0] r_pos;
    logic          l_req;
    logic [SW-1:0] l_pos;
    logic          r_gnt;
    logic          l_gnt;
    logic          rej;
    logic [2*S-1:0] board;
    logic [SW-1:0] empty_pos;
    logic [CW-1:0] moves;
    logic          done;
    logic          stuck;

    jam_referee #(.N(N), .CW(CW), .BACKSLIDE(0)) dut (
        .clock     (clock),
        .reset     (reset),
        .r_req     (r_req),
        .r_pos     (r_pos),
        .l_req     (l_req),
        .l_pos     (l_pos),
        .r_gnt     (r_gnt),
        .l_gnt     (l_gnt),
        .rej       (rej),
        .board     (board),
        .empty_pos (empty_pos),
        .moves     (moves),
        .done      (done),
        .stuck     (stuck)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int             kind;
        logic [2*S-1:0] brd;
        logic [SW-1:0]  epos;
        logic [CW-1:0]  mv;
        logic           dn;
        logic           st;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   fails  = 0;
    int   exp_moves = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // "RRRELLL" -> packed board, slot 0 is the leftmost character.
    function automatic logic [2*S-1:0] str2board(input string s);
        logic [2*S-1:0] b;
        b = '0;
        for (int i = 0; i < S; i++) begin
            if (s[i] == "R")      b[2*i +: 2] = 2'd2;
            else if (s[i] == "L") b[2*i +: 2] = 2'd1;
        end
        return b;
    endfunction

    function automatic logic [SW-1:0] str2empty(input string s);
        logic [SW-1:0] e;
        e = '0;
        for (int i = 0; i < S; i++) begin
            if (s[i] == "E") e = SW'(i);
        end
        return e;
    endfunction

    task automatic push(input int kind, input string b, input logic dn, input logic st);
        exp_t x;
        if (kind != K_REJ) exp_moves++;
        x.kind = kind;
        x.brd  = str2board(b);
        x.epos = str2empty(b);
        x.mv   = CW'(exp_moves);
        x.dn   = dn;
        x.st   = st;
        q.push_back(x);
    endtask

    // Monitor: every result pulse must match the oldest queued expectation.
    always @(negedge clock) begin
        if (r_gnt || l_gnt || rej) begin
            if (q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_pulse: got r_gnt=%0b l_gnt=%0b rej=%0b expected none", r_gnt, l_gnt, rej);
            end else begin
                exp_t x;
                int   k;
                x = q.pop_front();
                k = r_gnt ? K_RGNT : (l_gnt ? K_LGNT : K_REJ);
                chk("pulse_onehot", 32'(r_gnt) + 32'(l_gnt) + 32'(rej), 32'd1);
                chk("pulse_kind", 32'(k), 32'(x.kind));
                chk("board", 32'(board), 32'(x.brd));
                chk("empty_pos", 32'(empty_pos), 32'(x.epos));
                chk("moves", 32'(moves), 32'(x.mv));
                chk("done", 32'(done), 32'(x.dn));
                chk("stuck", 32'(stuck), 32'(x.st));
            end
        end
    end

    // Waits (bounded) for the next result pulse; called at a negedge.
    task automatic wait_pulse(input string name);
        for (int i = 0; i < 10; i++) begin
            @(posedge clock);
            @(negedge clock);
            if (r_gnt || l_gnt || rej) return;
        end
        checks++;
        fails++;
        $display("FAIL %s_timeout: got no pulse expected a gnt/rej within 10 cycles", name);
    endtask

    task automatic serve(input bit left, input int pos, input int kind,
                         input string b, input logic dn, input logic st);
        push(kind, b, dn, st);
        if (left) begin
            l_req = 1'b1;
            l_pos = SW'(pos);
        end else begin
            r_req = 1'b1;
            r_pos = SW'(pos);
        end
        wait_pulse(left ? "l_serve" : "r_serve");
        r_req = 1'b0;
        l_req = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        r_req = 1'b0;
        l_req = 1'b0;
        @(negedge clock);
        q.delete();
        exp_moves = 0;
        reset = 1'b0;
    endtask

    task automatic check_initial(input string name);
        chk({name, "_board"}, 32'(board), 32'(str2board("RRRELLL")));
        chk({name, "_empty"}, 32'(empty_pos), 32'd3);
        chk({name, "_moves"}, 32'(moves), 32'd0);
        chk({name, "_done"}, 32'(done), 32'd0);
        chk({name, "_stuck"}, 32'(stuck), 32'd0);
        chk({name, "_pulses"}, 32'({r_gnt, l_gnt, rej}), 32'd0);
    endtask

    // Counts pulses over a window where none may occur.
    task automatic check_quiet(input string name, input int cycles);
        int n;
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clock);
            @(negedge clock);
            if (r_gnt || l_gnt || rej) n++;
        end
        chk(name, 32'(n), 32'd0);
    endtask

    // Full solution: source slots, teams (1 = left) and resulting boards.
    int    sol_pos[15]  = '{2, 4, 5, 3, 1, 0, 2, 4, 6, 5, 3, 1, 2, 4, 3};
    bit    sol_left[15] = '{0, 1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 0};
    string sol_brd[15]  = '{"RRERLLL", "RRLRELL", "RRLRLEL", "RRLELRL", "RELRLRL",
                            "ERLRLRL", "LRERLRL", "LRLRERL", "LRLRLRE", "LRLRLER",
                            "LRLELRR", "LELRLRR", "LLERLRR", "LLLRERR", "LLLERRR"};

    initial begin
        reset = 1'b1;
        r_req = 1'b0;
        r_pos = '0;
        l_req = 1'b0;
        l_pos = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        check_initial("reset");
        check_quiet("idle_no_pulse", 2);

        // Illegal requests leave the board alone.
        serve(1'b1, 6, K_REJ, "RRRELLL", 1'b0, 1'b0);
        serve(1'b0, 4, K_REJ, "RRRELLL", 1'b0, 1'b0);

        // Simultaneous requests from reset: right first, then left jump.
        do_reset();
        push(K_RGNT, "RRERLLL", 1'b0, 1'b0);
        push(K_LGNT, "RRLRELL", 1'b0, 1'b0);
        r_req = 1'b1; r_pos = 3'd2;
        l_req = 1'b1; l_pos = 3'd4;
        wait_pulse("simul_r");
        r_req = 1'b0;
        wait_pulse("simul_l");
        l_req = 1'b0;

        // Full 15-move solution.
        do_reset();
        for (int i = 0; i < 15; i++) begin
            serve(sol_left[i], sol_pos[i], sol_left[i] ? K_LGNT : K_RGNT,
                  sol_brd[i], (i == 14), 1'b0);
        end
        r_req = 1'b1; r_pos = 3'd4;
        l_req = 1'b1; l_pos = 3'd2;
        check_quiet("done_ignores_req", 6);
        r_req = 1'b0;
        l_req = 1'b0;
        chk("done_board_hold", 32'(board), 32'(str2board("LLLERRR")));
        chk("done_moves_hold", 32'(moves), 32'd15);
        chk("done_flag_hold", 32'(done), 32'd1);

        // Dead end: right team walks into a stuck position.
        do_reset();
        serve(1'b0, 2, K_RGNT, "RRERLLL", 1'b0, 1'b0);
        serve(1'b0, 1, K_RGNT, "RERRLLL", 1'b0, 1'b0);
        serve(1'b0, 0, K_RGNT, "ERRRLLL", 1'b0, 1'b1);
        l_req = 1'b1; l_pos = 3'd4;
        check_quiet("stuck_ignores_req", 5);
        l_req = 1'b0;
        do_reset();
        check_initial("stuck_reset");

        // Reset during ACK restores everything, including the pointer.
        serve(1'b0, 2, K_RGNT, "RRERLLL", 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clock);
        check_initial("ack_reset");
        reset = 1'b0;
        q.delete();
        exp_moves = 0;
        push(K_RGNT, "RRERLLL", 1'b0, 1'b0);
        r_req = 1'b1; r_pos = 3'd2;
        l_req = 1'b1; l_pos = 3'd4;
        wait_pulse("ptr_after_reset");
        r_req = 1'b0;
        l_req = 1'b0;

        repeat (3) @(negedge clock);
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
